// File: rtl/clock_pkg.sv
// Shared encodings and limits for the HH:MM:SS clock controller.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } clock_state_e;

    localparam int SEC_HI_MAX = 5;
    localparam int MIN_HI_MAX = 5;
    localparam int HR_MAX     = 23;

    // BCD digits of the last hour value before the pair wraps to 00.
    localparam logic [3:0] HR_HI_WRAP = 4'(HR_MAX / 10);
    localparam logic [3:0] HR_LO_WRAP = 4'(HR_MAX % 10);

endpackage

// File: rtl/clock_ctrl_bcd_digit.sv
// Modulo-N BCD digit: counts on en, carries out when stepping past N-1.
module bcd_digit #(
    parameter int N = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       ld0,
    output logic [3:0] q,
    output logic       co
);

    localparam logic [3:0] LAST = 4'(N - 1);

    assign co = en && (q == LAST);

    // clr zeroes unconditionally; ld0 replaces the increment with a zero load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (en) begin
            if (ld0 || q == LAST) begin
                q <= 4'd0;
            end else begin
                q <= q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock_ctrl.sv
// 24-hour BCD clock with RUN / SET_HOUR / SET_MIN modes driven by two keys.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_EN_DEFAULT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       mode,
    input  logic       inc,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic [3:0] hr_lo,
    output logic [3:0] hr_hi,
    output logic [1:0] state,
    output logic       day_co
);

    localparam logic CNT_EN_RST = (TICK_EN_DEFAULT != 0);

    clock_state_e state_q, state_d;
    logic mode_q, inc_q;
    logic mode_edge, inc_edge;
    logic cnt_en;
    logic run_adv, hr_set, min_set, sec_clr;
    logic sec_lo_co, sec_hi_co, min_lo_co, min_hi_co;
    logic hr_run, hr_inc, hr_at_max;

    // A mode edge swallows a coincident inc edge rather than queueing it.
    assign mode_edge = mode && !mode_q;
    assign inc_edge  = inc && !inc_q && !mode_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= 1'b0;
            inc_q   <= 1'b0;
            state_q <= RUN;
            cnt_en  <= CNT_EN_RST;
        end else begin
            mode_q  <= mode;
            inc_q   <= inc;
            state_q <= state_d;
            if (sec_clr) begin
                cnt_en <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        run_adv = 1'b0;
        hr_set  = 1'b0;
        min_set = 1'b0;
        sec_clr = 1'b0;
        case (state_q)
            RUN: begin
                run_adv = tick && cnt_en;
                if (mode_edge) state_d = SET_HOUR;
            end
            SET_HOUR: begin
                hr_set = inc_edge;
                if (mode_edge) state_d = SET_MIN;
            end
            SET_MIN: begin
                min_set = inc_edge;
                sec_clr = mode_edge;
                if (mode_edge) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign state = state_q;

    bcd_digit #(.N(10)) u_sec_lo (
        .clk(clk), .rst(rst), .en(run_adv), .clr(sec_clr), .ld0(1'b0),
        .q(sec_lo), .co(sec_lo_co)
    );

    bcd_digit #(.N(SEC_HI_MAX + 1)) u_sec_hi (
        .clk(clk), .rst(rst), .en(sec_lo_co), .clr(sec_clr), .ld0(1'b0),
        .q(sec_hi), .co(sec_hi_co)
    );

    bcd_digit #(.N(10)) u_min_lo (
        .clk(clk), .rst(rst), .en(sec_hi_co || min_set), .clr(1'b0), .ld0(1'b0),
        .q(min_lo), .co(min_lo_co)
    );

    bcd_digit #(.N(MIN_HI_MAX + 1)) u_min_hi (
        .clk(clk), .rst(rst), .en(min_lo_co), .clr(1'b0), .ld0(1'b0),
        .q(min_hi), .co(min_hi_co)
    );

    // Minute carry reaches the hours only while running, never from SET_MIN.
    assign hr_run    = min_hi_co && run_adv;
    assign hr_inc    = hr_run || hr_set;
    assign hr_at_max = (hr_hi == HR_HI_WRAP) && (hr_lo == HR_LO_WRAP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hr_lo  <= 4'd0;
            hr_hi  <= 4'd0;
            day_co <= 1'b0;
        end else begin
            day_co <= hr_run && hr_at_max;
            if (hr_inc) begin
                if (hr_at_max) begin
                    hr_lo <= 4'd0;
                    hr_hi <= 4'd0;
                end else if (hr_lo == 4'd9) begin
                    hr_lo <= 4'd0;
                    hr_hi <= hr_hi + 4'd1;
                end else begin
                    hr_lo <= hr_lo + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl: vector table plus multi-cycle sequences.
module tb_clock_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic mode = 1'b0;
    logic inc = 1'b0;

    logic [3:0] a_sec_lo, a_sec_hi, a_min_lo, a_min_hi, a_hr_lo, a_hr_hi;
    logic [1:0] a_state;
    logic       a_day_co;
    logic [3:0] b_sec_lo, b_sec_hi, b_min_lo, b_min_hi, b_hr_lo, b_hr_hi;
    logic [1:0] b_state;
    logic       b_day_co;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int co_cnt   = 0;

    logic [26:0] exp_q[$];

    clock_ctrl #(.TICK_EN_DEFAULT(1)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .mode(mode), .inc(inc),
        .sec_lo(a_sec_lo), .sec_hi(a_sec_hi), .min_lo(a_min_lo), .min_hi(a_min_hi),
        .hr_lo(a_hr_lo), .hr_hi(a_hr_hi), .state(a_state), .day_co(a_day_co)
    );

    clock_ctrl #(.TICK_EN_DEFAULT(0)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .mode(mode), .inc(inc),
        .sec_lo(b_sec_lo), .sec_hi(b_sec_hi), .min_lo(b_min_lo), .min_hi(b_min_hi),
        .hr_lo(b_hr_lo), .hr_hi(b_hr_hi), .state(b_state), .day_co(b_day_co)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_day_co) co_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached, vectors=%0d", vec_cnt);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst  = 1'b0;
        tick = 1'b0;
        mode = 1'b0;
        inc  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        co_cnt = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b1;
        end
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic pulse_mode(input int n);
        repeat (n) begin
            @(negedge clk);
            mode = 1'b1;
            @(negedge clk);
            mode = 1'b0;
        end
    endtask

    task automatic pulse_inc(input int n);
        repeat (n) begin
            @(negedge clk);
            inc = 1'b1;
            @(negedge clk);
            inc = 1'b0;
        end
    endtask

    // ---------------- scoreboard ----------------
    function automatic logic [26:0] pk(input int h, input int m, input int s,
                                       input logic [1:0] st, input logic co);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), st, co};
    endfunction

    function automatic logic [26:0] obs(input bit sel_b);
        if (sel_b)
            return {b_hr_hi, b_hr_lo, b_min_hi, b_min_lo, b_sec_hi, b_sec_lo, b_state, b_day_co};
        return {a_hr_hi, a_hr_lo, a_min_hi, a_min_lo, a_sec_hi, a_sec_lo, a_state, a_day_co};
    endfunction

    task automatic chk(input string name, input bit sel_b, input int h, input int m,
                       input int s, input logic [1:0] st, input logic co);
        logic [26:0] e, got;
        exp_q.push_back(pk(h, m, s, st, co));
        e   = exp_q.pop_front();
        got = obs(sel_b);
        vec_cnt++;
        if (got !== e) begin
            miss_cnt++;
            $display("FAIL %s: got hh:mm:ss=%h:%h:%h st=%0d co=%b, expected %h:%h:%h st=%0d co=%b",
                     name, got[26:19], got[18:11], got[10:3], got[2:1], got[0],
                     e[26:19], e[18:11], e[10:3], e[2:1], e[0]);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int e);
        vec_cnt++;
        if (got != e) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, got, e);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       tick;
        logic       mode;
        logic       inc;
        int         h;
        int         m;
        int         s;
        logic [1:0] st;
    } vec_t;

    vec_t vt[17];

    initial begin
        vt[0]  = '{0, 0, 0,  0, 0, 0, 2'd0};
        vt[1]  = '{1, 0, 0,  0, 0, 1, 2'd0};
        vt[2]  = '{1, 0, 0,  0, 0, 2, 2'd0};
        vt[3]  = '{0, 0, 1,  0, 0, 2, 2'd0};  // inc ignored in RUN
        vt[4]  = '{0, 0, 0,  0, 0, 2, 2'd0};
        vt[5]  = '{1, 1, 0,  0, 0, 3, 2'd1};  // tick applied with mode edge
        vt[6]  = '{1, 1, 0,  0, 0, 3, 2'd1};  // held mode, tick ignored
        vt[7]  = '{0, 0, 1,  1, 0, 3, 2'd1};
        vt[8]  = '{0, 0, 1,  1, 0, 3, 2'd1};  // held inc
        vt[9]  = '{0, 0, 0,  1, 0, 3, 2'd1};
        vt[10] = '{0, 0, 1,  2, 0, 3, 2'd1};
        vt[11] = '{0, 1, 0,  2, 0, 3, 2'd2};
        vt[12] = '{0, 0, 1,  2, 1, 3, 2'd2};
        vt[13] = '{1, 0, 0,  2, 1, 3, 2'd2};  // tick ignored in SET_MIN
        vt[14] = '{0, 1, 1,  2, 1, 0, 2'd0};  // mode wins, seconds cleared
        vt[15] = '{1, 0, 0,  2, 1, 1, 2'd0};
        vt[16] = '{0, 0, 0,  2, 1, 1, 2'd0};

        // Reset values on both builds
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_a", 1'b0, 0, 0, 0, 2'd0, 1'b0);
        chk("reset_b", 1'b1, 0, 0, 0, 2'd0, 1'b0);
        rst = 1'b1;

        // Frozen counting until the first SET_MIN -> RUN
        tick_n(5);
        chk("frz_a_5ticks", 1'b0, 0, 0, 5, 2'd0, 1'b0);
        chk("frz_b_5ticks", 1'b1, 0, 0, 0, 2'd0, 1'b0);
        pulse_mode(3);
        chk("frz_a_modecyc", 1'b0, 0, 0, 0, 2'd0, 1'b0);
        chk("frz_b_modecyc", 1'b1, 0, 0, 0, 2'd0, 1'b0);
        tick_n(3);
        chk("frz_a_3ticks", 1'b0, 0, 0, 3, 2'd0, 1'b0);
        chk("frz_b_3ticks", 1'b1, 0, 0, 3, 2'd0, 1'b0);

        // Table
        do_reset();
        for (int i = 0; i < 17; i++) begin
            tick = vt[i].tick;
            mode = vt[i].mode;
            inc  = vt[i].inc;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 1'b0, vt[i].h, vt[i].m, vt[i].s, vt[i].st, 1'b0);
        end
        tick = 1'b0;
        mode = 1'b0;
        inc  = 1'b0;

        // 60 ticks from reset
        do_reset();
        tick_n(60);
        chk("run_60ticks", 1'b0, 0, 1, 0, 2'd0, 1'b0);
        chk_int("run_60_day_co_count", co_cnt, 0);

        // Preload 23:59 and roll over the day
        pulse_mode(1);
        pulse_inc(10);
        chk("set_hr_10", 1'b0, 10, 1, 0, 2'd1, 1'b0);
        pulse_inc(13);
        chk("set_hr_23", 1'b0, 23, 1, 0, 2'd1, 1'b0);
        pulse_mode(1);
        pulse_inc(58);
        chk("set_min_59", 1'b0, 23, 59, 0, 2'd2, 1'b0);
        pulse_mode(1);
        chk("back_to_run", 1'b0, 23, 59, 0, 2'd0, 1'b0);
        co_cnt = 0;
        tick_n(59);
        chk("pre_rollover", 1'b0, 23, 59, 59, 2'd0, 1'b0);
        tick_n(1);
        chk("rollover", 1'b0, 0, 0, 0, 2'd0, 1'b1);
        @(negedge clk);
        chk("rollover_next", 1'b0, 0, 0, 0, 2'd0, 1'b0);
        chk_int("rollover_day_co_count", co_cnt, 1);

        // Hour setting wraps 23 -> 00, ticks ignored
        tick_n(5);
        pulse_mode(1);
        tick = 1'b1;
        pulse_inc(24);
        chk("set_hr_wrap", 1'b0, 0, 0, 5, 2'd1, 1'b0);
        pulse_inc(1);
        tick = 1'b0;
        chk("set_hr_25", 1'b0, 1, 0, 5, 2'd1, 1'b0);

        // Held inc in SET_MIN, then simultaneous mode+inc
        pulse_mode(1);
        @(negedge clk);
        inc = 1'b1;
        repeat (10) @(negedge clk);
        inc = 1'b0;
        @(negedge clk);
        chk("held_inc", 1'b0, 1, 1, 5, 2'd2, 1'b0);
        mode = 1'b1;
        inc  = 1'b1;
        @(negedge clk);
        mode = 1'b0;
        inc  = 1'b0;
        chk("mode_inc_same", 1'b0, 1, 1, 0, 2'd0, 1'b0);

        // Mid-cycle async reset at 12:34:56
        pulse_mode(1);
        pulse_inc(11);
        pulse_mode(1);
        pulse_inc(33);
        pulse_mode(1);
        tick_n(56);
        chk("at_123456", 1'b0, 12, 34, 56, 2'd0, 1'b0);
        #2 rst = 1'b0;
        #1 chk("async_reset", 1'b0, 0, 0, 0, 2'd0, 1'b0);
        #1 rst = 1'b1;
        tick_n(1);
        chk("post_reset_tick", 1'b0, 0, 0, 1, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 Parameter TICK_EN_DEFAULT, default 1, meaning counting is enabled in RUN out of reset (0 = counting frozen until first mode cycle).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 tick  input  1  one-cycle 1 Hz enable pulse from the prescaler.
REQ-005 mode  input  1  debounced key level; rising edge advances the mode.
REQ-006 inc  input  1  debounced key level; rising edge increments the selected field.
REQ-007 sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi  output  4 each  BCD digits of HH:MM:SS.
REQ-008 state  output  2  current mode: 0 RUN, 1 SET_HOUR, 2 SET_MIN.
REQ-009 day_co  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.

Function
REQ-010 mode and inc rising edges are detected with one register stage each; action occurs the cycle after the edge register sees 0->1; a held level produces exactly one action.
REQ-011 FSM RUN -> SET_HOUR -> SET_MIN -> RUN on each mode edge; no other transitions; encoding 3 is unreachable and decodes to RUN on the next clock.
REQ-012 RUN: each tick increments SS; sec_lo wraps 9->0 with carry; sec_hi wraps 5->0 with carry to minutes; minutes wrap 59->00 with carry to hours; hours wrap 23->00.
REQ-013 Hour wrap is on the pair value: at 23 the carry sets 00; hr_lo wraps 9->0 only when hr_hi < 2; hr_lo wraps 3->0 when hr_hi = 2.
REQ-014 day_co is high for exactly the clock in which 23:59:59 advances to 00:00:00 and is low otherwise, including in the SET states.
REQ-015 RUN: inc edges are ignored.
REQ-016 SET_HOUR: tick ignored, all digits held; each inc edge increments hours mod 24 (23->00); no carry into or out of other fields.
REQ-017 SET_MIN: tick ignored; each inc edge increments minutes mod 60 (59->00); hours unaffected.
REQ-018 Transition SET_MIN -> RUN clears sec_hi and sec_lo to 0 in the same clock as the state change.
REQ-019 Simultaneous mode and inc edges: mode wins; inc is discarded, not queued.
REQ-020 tick coincident with a mode edge in RUN: the tick is applied, and state becomes SET_HOUR in the same clock.
REQ-021 If TICK_EN_DEFAULT = 0, ticks are ignored in RUN until the first SET_MIN -> RUN transition; after that, counting is permanent until reset.
REQ-022 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-023 rst low asynchronously forces all digits to 0, state to RUN, day_co to 0, edge registers to 0 and the count-enable flag to TICK_EN_DEFAULT.
REQ-024 Reset asserted mid-operation, in any state or during a carry ripple, yields the REQ-023 values with no partial update after release.
REQ-025 The first tick or edge is honoured on the first rising clk after rst deasserts.

Structure
REQ-026 Package clock_pkg holds the state encodings (RUN, SET_HOUR, SET_MIN) and limit constants (SEC_HI_MAX 5, MIN_HI_MAX 5, HR_MAX 23).
REQ-027 One sub-module, bcd_digit: a parameterised modulo-N digit with en, clr, a load-to-zero input and a carry output asserted when the digit is at N-1 and en is high; it is instantiated for the seconds and minutes digits.
REQ-028 The hour pair uses dedicated logic in clock_ctrl because of the 23 wrap.

Verification
REQ-029 From reset, apply 60 ticks in RUN -> 00:01:00 and day_co never high.
REQ-030 Preload via SET to 23:59, return to RUN (seconds 00), apply 59 ticks -> 23:59:59; the next tick -> 00:00:00 with day_co high for exactly one cycle.
REQ-031 Apply mode edge x1, then inc edges x25 -> state 1 and hours 01 (wrap 23->00 observed); minutes and seconds unchanged; ticks during the sequence ignored.
REQ-032 Hold inc high for 10 cycles in SET_MIN from 00 -> minutes 01 only; raise mode and inc in the same cycle -> state advances and minutes are unchanged.
REQ-033 At 12:34:56 in RUN, assert rst for a partial cycle between clocks -> all outputs 0 and state RUN immediately; after release, one tick -> 00:00:01.
REQ-034 With TICK_EN_DEFAULT = 0, 5 ticks after reset -> 00:00:00; after a full mode cycle plus 3 ticks -> 00:00:03.
